// File: rtl/ft_mon_pkg.sv
// rtl/ft_mon_pkg.sv - shared state encoding and default constants for the result monitor
//
// Purpose: monitor FSM state enum and default flag/result addresses and timeout.
// Ports:   none (package).
package ft_mon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        VOTE    = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_e;

    localparam logic [31:0] DEF_FLAG_ADDR   = 32'h0000_1000;
    localparam logic [31:0] DEF_RESULT_ADDR = 32'h0000_1004;
    localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd100;

endpackage

// File: rtl/ft_mon_channel.sv
// rtl/ft_mon_channel.sv - per-core write snooper capturing result word and completion flag
//
// Purpose: decode one core's data-write channel, capture its result and completion flag.
// Ports:   clk_i/rst_i    clock, async active-high reset
//          clear_i        arm pulse, wipes the capture
//          en_i           capture window (monitor in RUN)
//          wr_valid_i/wr_addr_i/wr_data_i  snooped write
//          result_o       captured result word
//          flag_o         completion flag already seen
//          flag_set_o     completion flag arriving this cycle
module ft_mon_channel #(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter logic [AW-1:0] FLAG_ADDR   = '0,
    parameter logic [AW-1:0] RESULT_ADDR = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic          wr_valid_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] result_o,
    output logic          flag_o,
    output logic          flag_set_o
);

    logic [DW-1:0] result_q, result_d;
    logic          flag_q, flag_d;
    logic          wr_en;

    assign wr_en      = en_i && wr_valid_i;
    // Zero writes to the flag word do not count as completion.
    assign flag_set_o = wr_en && (wr_addr_i == FLAG_ADDR) && (wr_data_i != '0);

    always_comb begin
        result_d = result_q;
        flag_d   = flag_q;
        if (clear_i) begin
            result_d = '0;
            flag_d   = 1'b0;
        end else begin
            // Once the core has signalled completion its result is frozen.
            if (wr_en && (wr_addr_i == RESULT_ADDR) && !flag_q) begin
                result_d = wr_data_i;
            end
            if (flag_set_o) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign result_o = result_q;
    assign flag_o   = flag_q;

endmodule

// File: rtl/ft_result_monitor.sv
// rtl/ft_result_monitor.sv - fault-tolerant multi-core result monitor with majority vote
//
// Purpose: snoop NUM_CH core write channels, wait for every completion flag (or time
//          out), then vote on the captured results and flag disagreeing cores.
// Ports:   clk_i/rst_i         clock, async active-high reset
//          start_i             arm pulse (honoured in IDLE, DONE, TIMEOUT)
//          wr_valid_i/wr_addr_i/wr_data_i  per-channel snooped writes
//          busy_o/done_o/timeout_o          status
//          result_o/agree_o/fault_mask_o    vote outcome
//          cycles_o            saturating RUN cycle count
module ft_result_monitor
    import ft_mon_pkg::*;
#(
    parameter int            NUM_CH      = 3,
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter logic [AW-1:0] FLAG_ADDR   = AW'(DEF_FLAG_ADDR),
    parameter logic [AW-1:0] RESULT_ADDR = AW'(DEF_RESULT_ADDR),
    parameter logic [31:0]   TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [NUM_CH-1:0]          wr_valid_i,
    input  logic [NUM_CH-1:0][AW-1:0]  wr_addr_i,
    input  logic [NUM_CH-1:0][DW-1:0]  wr_data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic [DW-1:0]              result_o,
    output logic                       agree_o,
    output logic [NUM_CH-1:0]          fault_mask_o,
    output logic [31:0]                cycles_o
);

    mon_state_e                 state_q, state_d;
    logic [NUM_CH-1:0]          flag, flag_set, flag_next;
    logic [NUM_CH-1:0][DW-1:0]  res;
    logic [DW-1:0]              result_q, result_d, vote_result;
    logic                       agree_q, agree_d, vote_agree, vote_found;
    logic [NUM_CH-1:0]          fault_q, fault_d, vote_fault;
    logic [31:0]                cycles_q, cycles_d, cycles_inc;
    logic [3:0]                 match_cnt;
    logic                       arm, in_run;

    assign in_run = (state_q == RUN);
    assign arm    = start_i && (state_q == IDLE || state_q == DONE || state_q == TIMEOUT);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ft_mon_channel #(
            .AW          (AW),
            .DW          (DW),
            .FLAG_ADDR   (FLAG_ADDR),
            .RESULT_ADDR (RESULT_ADDR)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (arm),
            .en_i       (in_run),
            .wr_valid_i (wr_valid_i[c]),
            .wr_addr_i  (wr_addr_i[c]),
            .wr_data_i  (wr_data_i[c]),
            .result_o   (res[c]),
            .flag_o     (flag[c]),
            .flag_set_o (flag_set[c])
        );
    end

    // Flags including this cycle's arrivals, so a last flag on the timeout cycle still wins.
    assign flag_next  = flag | flag_set;
    assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    // Majority vote over the frozen captures. With two channels the second index is
    // written as NUM_CH-1 so the expression stays in range for every legal NUM_CH.
    always_comb begin
        vote_result = res[0];
        vote_agree  = 1'b0;
        vote_found  = 1'b0;
        match_cnt   = '0;
        if (NUM_CH == 1) begin
            vote_agree = 1'b1;
        end else if (NUM_CH == 2) begin
            vote_agree = (res[0] == res[NUM_CH-1]);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                match_cnt = '0;
                for (int j = 0; j < NUM_CH; j++) begin
                    if (res[j] == res[i]) begin
                        match_cnt = match_cnt + 4'd1;
                    end
                end
                if (!vote_found && (match_cnt > 4'(NUM_CH / 2))) begin
                    vote_found  = 1'b1;
                    vote_result = res[i];
                end
            end
            vote_agree = vote_found;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            vote_fault[c] = vote_agree ? (res[c] != vote_result) : 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        agree_d  = agree_q;
        fault_d  = fault_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE, DONE, TIMEOUT: begin
                if (start_i) begin
                    state_d  = RUN;
                    result_d = '0;
                    agree_d  = 1'b0;
                    fault_d  = '0;
                    cycles_d = '0;
                end
            end
            RUN: begin
                cycles_d = cycles_inc;
                if (&flag_next) begin
                    state_d = VOTE;
                end else if (cycles_inc >= TIMEOUT_CYC) begin
                    state_d  = TIMEOUT;
                    result_d = '0;
                    agree_d  = 1'b0;
                    fault_d  = ~flag_next;
                end
            end
            VOTE: begin
                state_d  = DONE;
                result_d = vote_result;
                agree_d  = vote_agree;
                fault_d  = vote_fault;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            agree_q  <= 1'b0;
            fault_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            agree_q  <= agree_d;
            fault_q  <= fault_d;
            cycles_q <= cycles_d;
        end
    end

    assign busy_o       = (state_q == RUN) || (state_q == VOTE);
    assign done_o       = (state_q == DONE);
    assign timeout_o    = (state_q == TIMEOUT);
    assign result_o     = result_q;
    assign agree_o      = agree_q;
    assign fault_mask_o = fault_q;
    assign cycles_o     = cycles_q;

endmodule
